// File: rtl/lfsr_stream_arbiter_if.sv
// Requester-side bus of the LFSR stream arbiter.
// Level request in, one-hot grant / word strobe / word out.
interface lfsr_stream_arbiter_if #(
  parameter int NBITS = 8
) ();
  logic [1:0]       i_req;
  logic [1:0]       o_gnt;
  logic [1:0]       o_valid;
  logic [NBITS-1:0] o_word;

  modport slave (
    input  i_req,
    output o_gnt,
    output o_valid,
    output o_word
  );

  modport master (
    output i_req,
    input  o_gnt,
    input  o_valid,
    input  o_word
  );
endinterface

// File: rtl/lfsr_stream_arbiter.sv
// Seed sequencer and two-way word arbiter for the serial LFSR.
// Define LFSR_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module lfsr_stream_arbiter #(
  parameter int NBITS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_lfsr_bit,
  output logic                  o_lfsr_reset,
  output logic                  o_load_seed,
  output logic [31:0]           o_seed,
  input  logic                  i_seed_wr,
  input  logic [31:0]           i_seed,
  lfsr_stream_arbiter_if.slave  bus
);

  localparam int CW = $clog2(NBITS) + 1;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOAD,
    GATHER,
    DONE
  } state_t;

  state_t           state_q;
  logic             seed_pend_q;
  logic [31:0]      pend_seed_q;
  logic [31:0]      seed_q;
  logic             load_seed_q;
  logic             lfsr_reset_q;
  logic [1:0]       gnt_q;
  logic [1:0]       valid_q;
  logic [NBITS-1:0] word_q;
  logic [NBITS-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic             gidx_q;
`ifndef LFSR_ARB_FIXED_PRIO_EN
  logic             last_q;
`endif

  logic             win_d;
  logic [NBITS-1:0] sr_d;

  // Pick the requester to grant out of IDLE.
  always_comb begin
    win_d = 1'b0;
`ifdef LFSR_ARB_FIXED_PRIO_EN
    win_d = bus.i_req[0] ? 1'b0 : 1'b1;
`else
    if (bus.i_req[0] && bus.i_req[1])
      win_d = ~last_q;
    else
      win_d = bus.i_req[0] ? 1'b0 : 1'b1;
`endif
  end

  // Next shift-register value; first bit ends up in the MSB.
  always_comb begin
    sr_d = {sr_q[NBITS-2:0], i_lfsr_bit};
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= INIT;
      seed_pend_q  <= 1'b0;
      pend_seed_q  <= '0;
      seed_q       <= '0;
      load_seed_q  <= 1'b0;
      lfsr_reset_q <= 1'b1;
      gnt_q        <= '0;
      valid_q      <= '0;
      word_q       <= '0;
      sr_q         <= '0;
      cnt_q        <= '0;
      gidx_q       <= 1'b0;
`ifndef LFSR_ARB_FIXED_PRIO_EN
      last_q       <= 1'b1;
`endif
    end else begin
      if (i_seed_wr) begin
        pend_seed_q <= i_seed;
        seed_pend_q <= 1'b1;
      end
      unique case (state_q)
        INIT: begin
          if (seed_pend_q) begin
            state_q      <= LOAD;
            load_seed_q  <= 1'b1;
            seed_q       <= pend_seed_q;
            lfsr_reset_q <= 1'b0;
          end
        end
        IDLE: begin
          if (seed_pend_q) begin
            state_q     <= LOAD;
            load_seed_q <= 1'b1;
            seed_q      <= pend_seed_q;
          end else if (|bus.i_req) begin
            state_q <= GATHER;
            gidx_q  <= win_d;
            gnt_q   <= win_d ? 2'b10 : 2'b01;
            cnt_q   <= '0;
          end
        end
        LOAD: begin
          state_q     <= IDLE;
          load_seed_q <= 1'b0;
          if (!i_seed_wr)
            seed_pend_q <= 1'b0;
        end
        GATHER: begin
          if (!bus.i_req[gidx_q]) begin
            state_q <= IDLE;
            gnt_q   <= '0;
          end else begin
            sr_q <= sr_d;
            if (cnt_q == CW'(NBITS - 1)) begin
              state_q <= DONE;
              word_q  <= sr_d;
              valid_q <= gnt_q;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          valid_q <= '0;
`ifndef LFSR_ARB_FIXED_PRIO_EN
          last_q  <= gidx_q;
`endif
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign o_lfsr_reset = lfsr_reset_q;
  assign o_load_seed  = load_seed_q;
  assign o_seed       = seed_q;
  assign bus.o_gnt    = gnt_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_word   = word_q;

endmodule

// File: tb/tb_lfsr_stream_arbiter.sv
// Bench for lfsr_stream_arbiter: vector table plus corner sequences.
// Words are checked against a scoreboard queue on every o_valid.
module tb_lfsr_stream_arbiter;
  localparam int NBITS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        lbit;
  logic        lrst;
  logic        lseed;
  logic [31:0] oseed;
  logic        seed_wr;
  logic [31:0] seed;

  lfsr_stream_arbiter_if #(.NBITS(NBITS)) bus ();

  lfsr_stream_arbiter #(.NBITS(NBITS)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_lfsr_bit   (lbit),
    .o_lfsr_reset (lrst),
    .o_load_seed  (lseed),
    .o_seed       (oseed),
    .i_seed_wr    (seed_wr),
    .i_seed       (seed),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]       v;
    logic [NBITS-1:0] w;
  } exp_t;

  typedef struct {
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic [NBITS-1:0] word;
    bit               rel;
    bit               rs;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every word strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (bus.o_valid !== 2'b00) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected", {30'd0, bus.o_valid}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_valid", {30'd0, bus.o_valid}, {30'd0, mon_e.v});
        chk("sb_word", {24'd0, bus.o_word}, {24'd0, mon_e.w});
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.i_req = 2'b00;
    seed_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_lrst", {31'd0, lrst}, 32'd1);
    chk("rst_lseed", {31'd0, lseed}, 32'd0);
    chk("rst_seed", oseed, 32'd0);
    chk("rst_gnt", {30'd0, bus.o_gnt}, 32'd0);
    chk("rst_valid", {30'd0, bus.o_valid}, 32'd0);
    chk("rst_word", {24'd0, bus.o_word}, 32'd0);
  endtask

  task automatic seed_load(input logic [31:0] v);
    seed_wr = 1'b1;
    seed = v;
    @(negedge clk);
    seed_wr = 1'b0;
    chk("ld_early", {31'd0, lseed}, 32'd0);
    @(negedge clk);
    chk("ld_pulse", {31'd0, lseed}, 32'd1);
    chk("ld_seed", oseed, v);
    chk("ld_lrst", {31'd0, lrst}, 32'd0);
    chk("ld_gnt", {30'd0, bus.o_gnt}, 32'd0);
    @(negedge clk);
    chk("ld_end", {31'd0, lseed}, 32'd0);
  endtask

  // Entered at a falling edge with the DUT in IDLE.
  task automatic gather(input logic [1:0] req, input logic [1:0] eg,
                        input logic [NBITS-1:0] w, input bit rel,
                        input int abort_c, input int rst_c,
                        input int wr_c);
    logic [NBITS-1:0] prev;
    prev = bus.o_word;
    bus.i_req = req;
    if (abort_c < 0 && rst_c < 0)
      sbq.push_back('{eg, w});
    @(negedge clk);
    chk("gnt", {30'd0, bus.o_gnt}, {30'd0, eg});
    for (int c = 1; c <= NBITS; c++) begin
      lbit = w[NBITS-c];
      seed_wr = (wr_c > 0) && (c == wr_c || c == wr_c + 1);
      seed = (c == wr_c) ? 32'h1 : 32'h2;
      if (c == abort_c) begin
        bus.i_req = 2'b00;
        @(negedge clk);
        chk("abort_gnt", {30'd0, bus.o_gnt}, 32'd0);
        chk("abort_valid", {30'd0, bus.o_valid}, 32'd0);
        chk("abort_word", {24'd0, bus.o_word}, {24'd0, prev});
        return;
      end
      if (c == rst_c) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_req = 2'b00;
        seed_wr = 1'b0;
        chk("mrst_gnt", {30'd0, bus.o_gnt}, 32'd0);
        chk("mrst_valid", {30'd0, bus.o_valid}, 32'd0);
        chk("mrst_word", {24'd0, bus.o_word}, 32'd0);
        chk("mrst_lrst", {31'd0, lrst}, 32'd1);
        return;
      end
      @(negedge clk);
      if (c == NBITS - 1)
        chk("valid_early", {30'd0, bus.o_valid}, 32'd0);
    end
    seed_wr = 1'b0;
    chk("valid", {30'd0, bus.o_valid}, {30'd0, eg});
    chk("word", {24'd0, bus.o_word}, {24'd0, w});
    chk("done_gnt", {30'd0, bus.o_gnt}, {30'd0, eg});
    if (rel)
      bus.i_req = 2'b00;
    @(negedge clk);
    chk("idle_gnt", {30'd0, bus.o_gnt}, 32'd0);
    chk("idle_valid", {30'd0, bus.o_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g_seed;
    tbl[0] = '{2'b01, 2'b01, 8'hB2, 1'b1, 1'b0};
`ifdef LFSR_ARB_FIXED_PRIO_EN
    tbl[1] = '{2'b11, 2'b01, 8'h5A, 1'b0, 1'b1};
    tbl[2] = '{2'b11, 2'b01, 8'hC3, 1'b0, 1'b0};
    tbl[3] = '{2'b11, 2'b01, 8'h0F, 1'b1, 1'b0};
    g_seed = 2'b01;
`else
    tbl[1] = '{2'b11, 2'b01, 8'h5A, 1'b0, 1'b1};
    tbl[2] = '{2'b11, 2'b10, 8'hC3, 1'b0, 1'b0};
    tbl[3] = '{2'b11, 2'b01, 8'h0F, 1'b1, 1'b0};
    g_seed = 2'b10;
`endif
    rst = 1'b1;
    lbit = 1'b0;
    seed_wr = 1'b0;
    seed = '0;
    bus.i_req = 2'b00;
    @(negedge clk);
    do_reset();

    bus.i_req = 2'b11;
    repeat (6) begin
      @(negedge clk);
      chk("init_gnt", {30'd0, bus.o_gnt}, 32'd0);
      chk("init_lrst", {31'd0, lrst}, 32'd1);
    end
    bus.i_req = 2'b00;
    seed_load(32'hDEADBEEF);

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].rs) begin
        do_reset();
        seed_load(32'h1234);
      end
      gather(tbl[i].req, tbl[i].gnt, tbl[i].word, tbl[i].rel, -1, -1, -1);
    end

    do_reset();
    seed_load(32'h5);
    gather(2'b10, 2'b10, 8'h96, 1'b1, -1, -1, -1);
    gather(2'b01, 2'b01, 8'hFF, 1'b0, 4, -1, -1);
    gather(2'b11, 2'b01, 8'h3C, 1'b1, -1, -1, -1);

    gather(2'b01, 2'b01, 8'hA5, 1'b0, -1, -1, 3);
    bus.i_req = 2'b11;
    @(negedge clk);
    chk("swg_pulse", {31'd0, lseed}, 32'd1);
    chk("swg_seed", oseed, 32'h2);
    chk("swg_gnt0", {30'd0, bus.o_gnt}, 32'd0);
    @(negedge clk);
    chk("swg_once", {31'd0, lseed}, 32'd0);
    chk("swg_gnt1", {30'd0, bus.o_gnt}, 32'd0);
    @(negedge clk);
    chk("swg_grant", {30'd0, bus.o_gnt}, {30'd0, g_seed});
    chk("swg_noload", {31'd0, lseed}, 32'd0);

    do_reset();
    seed_load(32'h7);
    gather(2'b01, 2'b01, 8'h81, 1'b0, -1, 5, -1);

    chk("sb_drain", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
